regfile_read_arbiter: RTL

Shares the single 32x32 register-file read port (5-bit register select into the 32:1 read mux, 32-bit data back) among NREQ requesters. Each cycle a round-robin arbiter picks one pending request, drives the read select and registers the returned word with a one-cycle response. Same-cycle writes to the selected register are forwarded, so responses always reflect the post-write value. Sits between the pipeline's read clients (decode, debug, scrubber) and the register file's read port.

---
 rtl/regfile_read_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the single register-file read port among NREQ clients.
// Grant and read select are combinational; the response is registered one cycle later.
module regfile_read_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   gnt,
  output logic [4:0]        rd_sel,
  input  logic [31:0]       rd_data,
  input  logic              ctrl_writeEnable,
  input  logic [4:0]        ctrl_writeReg,
  input  logic [31:0]       data_writeReg,
  output logic              resp_valid,
  output logic [PW-1:0]     resp_id,
  output logic [31:0]       resp_data
);

  logic [PW-1:0]   r_ptr;
  logic            r_resp_valid;
  logic [PW-1:0]   r_resp_id;
  logic [31:0]     r_resp_data;

  logic            w_any;
  logic [PW-1:0]   w_winner;
  logic [PW:0]     w_scan;
  logic [NREQ-1:0] w_gnt;
  logic [4:0]      w_rd_sel;
  logic [PW-1:0]   w_ptr_nxt;
  logic            w_fwd;
  logic [31:0]     w_data;

  // Scan from r_ptr upward, wrapping modulo NREQ; first pending request wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_scan   = '0;
    w_gnt    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_scan >= (PW+1)'(NREQ)) begin
        w_scan = w_scan - (PW+1)'(NREQ);
      end
      if (!w_any && req[w_scan[PW-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_scan[PW-1:0];
      end
    end
    if (w_any) begin
      w_gnt[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_rd_sel = 5'd0;
    if (w_any) begin
      w_rd_sel = req_addr[5*w_winner +: 5];
    end
  end

  assign w_ptr_nxt = (w_winner == PW'(NREQ-1)) ? '0 : w_winner + PW'(1);

  // r0 is hardwired zero in the register file, so writes to it are never forwarded.
  assign w_fwd  = w_any && ctrl_writeEnable &&
                  (ctrl_writeReg == w_rd_sel) && (ctrl_writeReg != 5'd0);
  assign w_data = w_fwd ? data_writeReg : rd_data;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_ptr        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
    end else if (w_any) begin
      r_ptr        <= w_ptr_nxt;
      r_resp_valid <= 1'b1;
      r_resp_id    <= w_winner;
      r_resp_data  <= w_data;
    end else begin
      r_resp_valid <= 1'b0;
    end
  end

  assign gnt        = w_gnt;
  assign rd_sel     = w_rd_sel;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;

endmodule
